reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/riscv_config_pkg.sv | 9 +
 rtl/riscv_types_pkg.sv | 10 +
 rtl/reg_scoreboard_if.sv | 37 +++
 rtl/sat_counter.sv | 32 +++
 rtl/reg_scoreboard.sv | 137 +++++++++++++
 tb/tb_reg_scoreboard.sv | 296 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_config_pkg.sv
// Build-time defaults for the register scoreboard and the interface it shares with Decode.
package riscv_config_pkg;

    localparam int NUM_REGS_DEFAULT        = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;
    localparam int NUM_SRC_DEFAULT         = 2;
    localparam int CNT_W_DEFAULT           = 32;

endpackage

// File: rtl/riscv_types_pkg.sv
// Shared type definitions for the scoreboard control path.
package riscv_types_pkg;

    // IDLE: normal issue; DRAIN: waiting for every outstanding writer to return
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode <-> scoreboard bundle: issue request, long-latency writeback, fence and status.
interface reg_scoreboard_if #(
    parameter int NUM_REGS = riscv_config_pkg::NUM_REGS_DEFAULT,
    parameter int NUM_SRC  = riscv_config_pkg::NUM_SRC_DEFAULT,
    parameter int CNT_W    = riscv_config_pkg::CNT_W_DEFAULT
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                           issue_valid_i;
    logic [NUM_SRC-1:0][ADDR_W-1:0] issue_rs_addr_i;
    logic [NUM_SRC-1:0]             issue_rs_used_i;
    logic [ADDR_W-1:0]              issue_rd_addr_i;
    logic                           issue_long_lat_i;
    logic                           wb_valid_i;
    logic [ADDR_W-1:0]              wb_rd_addr_i;
    logic                           fence_req_i;

    logic                           stall_o;
    logic                           fence_done_o;
    logic                           busy_o;
    logic                           err_o;
    logic [CNT_W-1:0]               stall_cycles_o;

    modport master (
        output issue_valid_i, issue_rs_addr_i, issue_rs_used_i, issue_rd_addr_i,
               issue_long_lat_i, wb_valid_i, wb_rd_addr_i, fence_req_i,
        input  stall_o, fence_done_o, busy_o, err_o, stall_cycles_o
    );

    modport slave (
        input  issue_valid_i, issue_rs_addr_i, issue_rs_used_i, issue_rd_addr_i,
               issue_long_lat_i, wb_valid_i, wb_rd_addr_i, fence_req_i,
        output stall_o, fence_done_o, busy_o, err_o, stall_cycles_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state math lives in always_comb.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/reg_scoreboard.sv
// In-order issue scoreboard: RAW/WAW/capacity stalls, long-latency writer tracking and fence drain.
// Define SCOREBOARD_WB_BYPASS_EN to let a same-cycle writeback release hazards and capacity.
module reg_scoreboard
    import riscv_types_pkg::*;
#(
    parameter int NUM_REGS        = riscv_config_pkg::NUM_REGS_DEFAULT,
    parameter int NUM_SRC         = riscv_config_pkg::NUM_SRC_DEFAULT,
    parameter int MAX_OUTSTANDING = riscv_config_pkg::MAX_OUTSTANDING_DEFAULT,
    parameter int CNT_W           = riscv_config_pkg::CNT_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    reg_scoreboard_if.slave sb_if
);

    localparam int                OCNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCNT_W-1:0] MAX_CNT = OCNT_W'(MAX_OUTSTANDING);

    sb_state_e           state_q, state_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OCNT_W-1:0]   count_q, count_d;
    logic                err_q, err_d;

    logic                wb_hit;
    logic                wb_bad;
    logic [NUM_REGS-1:0] hazard_view;
    logic                cap_full;
    logic                raw;
    logic                waw;
    logic                stall;
    logic                accept;
    logic                set_rd;
    logic                fence_done;
    logic [CNT_W-1:0]    stall_cycles;

    // Hazard detection and issue acceptance
    always_comb begin
        wb_hit = sb_if.wb_valid_i && (sb_if.wb_rd_addr_i != '0)
                 && pending_q[sb_if.wb_rd_addr_i];
        wb_bad = sb_if.wb_valid_i && !wb_hit;

        hazard_view = pending_q;
        cap_full    = (count_q == MAX_CNT);
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The returning result is forwarded, so it neither blocks a reader nor holds a slot.
        if (wb_hit) begin
            hazard_view[sb_if.wb_rd_addr_i] = 1'b0;
            cap_full                        = 1'b0;
        end
`endif

        raw = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sb_if.issue_rs_used_i[s] && hazard_view[sb_if.issue_rs_addr_i[s]]) begin
                raw = 1'b1;
            end
        end
        waw = sb_if.issue_long_lat_i && hazard_view[sb_if.issue_rd_addr_i];

        stall  = (state_q == DRAIN)
                 || (sb_if.issue_valid_i && (raw || waw || (sb_if.issue_long_lat_i && cap_full)));
        accept = sb_if.issue_valid_i && !stall;
        set_rd = accept && sb_if.issue_long_lat_i && (sb_if.issue_rd_addr_i != '0);
    end

    // Pending-bit, outstanding-count and error bookkeeping
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = err_q | wb_bad;

        if (wb_hit) begin
            pending_d[sb_if.wb_rd_addr_i] = 1'b0;
        end
        // Set after clear: a new writer to the register just written back keeps it pending.
        if (set_rd) begin
            pending_d[sb_if.issue_rd_addr_i] = 1'b1;
        end

        case ({set_rd, wb_hit})
            2'b10:   count_d = count_q + OCNT_W'(1);
            2'b01:   count_d = count_q - OCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Fence FSM: DRAIN holds Decode until every writer has returned
    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (sb_if.fence_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d    = IDLE;
                    fence_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the pending vector is plain flops and is cleared on reset; a stale bit would stall Decode forever.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .clr_i   (rst_i),
        .inc_i   (stall),
        .count_o (stall_cycles)
    );

    assign sb_if.stall_o        = stall;
    assign sb_if.fence_done_o   = fence_done;
    assign sb_if.busy_o         = (count_q != '0);
    assign sb_if.err_o          = err_q;
    assign sb_if.stall_cycles_o = stall_cycles;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scenarios plus randomized traffic, checked every cycle against a set-based scoreboard model.
module tb_reg_scoreboard;
    import riscv_types_pkg::*;

    localparam int     NUM_REGS  = 32;
    localparam int     NUM_SRC   = 2;
    localparam int     MAX_OUT   = 4;
    localparam int     CNT_W     = 32;
    localparam int     ADDR_W    = $clog2(NUM_REGS);
    localparam longint STALL_MAX = (longint'(1) << CNT_W) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) sb_if ();

    reg_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .NUM_SRC         (NUM_SRC),
        .MAX_OUTSTANDING (MAX_OUT),
        .CNT_W           (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb_if (sb_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model: set of registers awaiting a result ----------------
    bit     m_pend [NUM_REGS];
    bit     m_drain;
    bit     m_err;
    longint m_stalls;

    function automatic int m_count();
        int n = 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return n;
    endfunction

    // A register blocks a new reader/writer if it awaits a result not being delivered (with bypass) right now.
    function automatic bit m_blocked(input int r);
        if (!m_pend[r]) return 1'b0;
        if (BYPASS && sb_if.wb_valid_i && (int'(sb_if.wb_rd_addr_i) == r)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        int free_slots;
        free_slots = MAX_OUT - m_count();
        if (m_drain) return 1'b1;
        if (!sb_if.issue_valid_i) return 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sb_if.issue_rs_used_i[s] && m_blocked(int'(sb_if.issue_rs_addr_i[s]))) return 1'b1;
        end
        if (sb_if.issue_long_lat_i) begin
            if (m_blocked(int'(sb_if.issue_rd_addr_i))) return 1'b1;
            if (BYPASS && sb_if.wb_valid_i && m_pend[sb_if.wb_rd_addr_i]) free_slots++;
            if (free_slots <= 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Compare process: outputs checked mid-cycle, model advanced to the next edge's state.
    initial begin
        bit exp_stall;
        bit exp_done;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_drain  = 1'b0;
        m_err    = 1'b0;
        m_stalls = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_stall = m_stall();
            exp_done  = m_drain && (m_count() == 0);
            check("model stall_o", sb_if.stall_o, exp_stall);
            check("model fence_done_o", sb_if.fence_done_o, exp_done);
            check("model busy_o", sb_if.busy_o, m_count() != 0);
            check("model err_o", sb_if.err_o, m_err);
            check("model stall_cycles_o", sb_if.stall_cycles_o, m_stalls);
            if (rst) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_drain  = 1'b0;
                m_err    = 1'b0;
                m_stalls = 0;
            end else begin
                if (exp_stall && (m_stalls < STALL_MAX)) m_stalls++;
                if (sb_if.wb_valid_i) begin
                    if (m_pend[sb_if.wb_rd_addr_i]) m_pend[sb_if.wb_rd_addr_i] = 1'b0;
                    else m_err = 1'b1;
                end
                if (sb_if.issue_valid_i && !exp_stall && sb_if.issue_long_lat_i
                    && (sb_if.issue_rd_addr_i != '0)) begin
                    m_pend[sb_if.issue_rd_addr_i] = 1'b1;
                end
                if (m_drain) begin
                    if (exp_done) m_drain = 1'b0;
                end else if (sb_if.fence_req_i) begin
                    m_drain = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        sb_if.issue_valid_i    = 1'b0;
        sb_if.issue_rs_addr_i  = '0;
        sb_if.issue_rs_used_i  = '0;
        sb_if.issue_rd_addr_i  = '0;
        sb_if.issue_long_lat_i = 1'b0;
        sb_if.wb_valid_i       = 1'b0;
        sb_if.wb_rd_addr_i     = '0;
        sb_if.fence_req_i      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rs0, input int rs1, input logic [1:0] used, input int rd,
                         input bit long_lat);
        sb_if.issue_valid_i      = 1'b1;
        sb_if.issue_rs_addr_i[0] = ADDR_W'(rs0);
        sb_if.issue_rs_addr_i[1] = ADDR_W'(rs1);
        sb_if.issue_rs_used_i    = used;
        sb_if.issue_rd_addr_i    = ADDR_W'(rd);
        sb_if.issue_long_lat_i   = long_lat;
    endtask

    task automatic do_wb(input int r);
        sb_if.wb_valid_i   = 1'b1;
        sb_if.wb_rd_addr_i = ADDR_W'(r);
    endtask

    bit drain_stall [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit drain_done  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int drain_wb    [5] = '{6, 7, 8, 0, 0};

    initial begin
        int done_seen;
        int pend_list [$];
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset stall_o", sb_if.stall_o, 0);
        check("reset busy_o", sb_if.busy_o, 0);
        check("reset err_o", sb_if.err_o, 0);
        check("reset fence_done_o", sb_if.fence_done_o, 0);
        check("reset stall_cycles_o", sb_if.stall_cycles_o, 0);

        // RAW on a load result, then the bypass/no-bypass difference on the writeback cycle
        tick(); idle(); issue(0, 0, 2'b00, 5, 1'b1); #1;
        check("raw load accepted", sb_if.stall_o, 0);
        tick(); idle(); issue(5, 0, 2'b01, 10, 1'b0); #1;
        check("raw stall c1", sb_if.stall_o, 1);
        tick(); idle(); issue(5, 0, 2'b01, 10, 1'b0); #1;
        check("raw stall c2", sb_if.stall_o, 1);
        tick(); idle(); issue(5, 0, 2'b01, 10, 1'b0); do_wb(5); #1;
        check("raw wb-cycle stall", sb_if.stall_o, BYPASS ? 0 : 1);
        tick(); idle(); issue(5, 0, 2'b01, 10, 1'b0); #1;
        check("raw released", sb_if.stall_o, 0);
        check("raw stall_cycles", sb_if.stall_cycles_o, BYPASS ? 2 : 3);
        check("raw busy clear", sb_if.busy_o, 0);

        // Capacity: four writers fill the table, the fifth waits for a slot
        for (int r = 1; r <= 4; r++) begin
            tick(); idle(); issue(0, 0, 2'b00, r, 1'b1); #1;
            check("cap fill accepted", sb_if.stall_o, 0);
        end
        tick(); idle(); issue(0, 0, 2'b00, 6, 1'b1); #1;
        check("cap full stall", sb_if.stall_o, 1);
        check("cap full busy", sb_if.busy_o, 1);
        tick(); idle(); issue(0, 0, 2'b00, 6, 1'b1); do_wb(1); #1;
        check("cap wb-cycle stall", sb_if.stall_o, BYPASS ? 0 : 1);
        tick(); idle(); issue(0, 0, 2'b00, 6, 1'b1); #1;
        check("cap 5th next cycle", sb_if.stall_o, BYPASS ? 1 : 0);

        // Simultaneous set x7 / clear x3 at count 2
        tick(); idle(); do_wb(2);
        tick(); idle(); do_wb(4);
        tick(); idle(); issue(0, 0, 2'b00, 7, 1'b1); do_wb(3); #1;
        check("sim count before", dut.count_q, 2);
        check("sim issue accepted", sb_if.stall_o, 0);
        tick(); idle(); issue(3, 0, 2'b01, 12, 1'b0); #1;
        check("sim count after", dut.count_q, 2);
        check("sim x3 cleared", sb_if.stall_o, 0);
        tick(); idle(); issue(0, 7, 2'b10, 12, 1'b0); #1;
        check("sim x7 pending", sb_if.stall_o, 1);

        // Drain with three outstanding writers; a second fence request mid-drain is ignored
        tick(); idle(); issue(0, 0, 2'b00, 8, 1'b1); #1;
        check("drain third writer", sb_if.stall_o, 0);
        tick(); idle(); sb_if.fence_req_i = 1'b1; #1;
        check("drain request cycle", sb_if.stall_o, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); idle();
            if (drain_wb[i] != 0) do_wb(drain_wb[i]);
            if (i == 1) sb_if.fence_req_i = 1'b1;
            #1;
            check("drain stall_o", sb_if.stall_o, drain_stall[i]);
            check("drain fence_done_o", sb_if.fence_done_o, drain_done[i]);
            done_seen += int'(sb_if.fence_done_o);
        end
        check("drain done pulses", done_seen, 1);

        // Fence with nothing outstanding: one stall cycle, then done
        tick(); idle(); sb_if.fence_req_i = 1'b1; #1;
        check("empty fence req", sb_if.stall_o, 0);
        tick(); idle(); #1;
        check("empty fence done", sb_if.fence_done_o, 1);
        check("empty fence stall", sb_if.stall_o, 1);
        tick(); idle(); #1;
        check("empty fence after", sb_if.fence_done_o, 0);

        // Protocol errors are sticky and leave the count alone; reset clears them
        tick(); idle(); issue(0, 0, 2'b00, 11, 1'b1);
        tick(); idle(); do_wb(9); #1;
        check("err before", sb_if.err_o, 0);
        tick(); idle(); #1;
        check("err set", sb_if.err_o, 1);
        check("err count kept", dut.count_q, 1);
        tick(); idle(); do_wb(0);
        tick(); idle(); #1;
        check("err sticky", sb_if.err_o, 1);
        check("err x0 count kept", dut.count_q, 1);
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0; idle(); #1;
        check("err reset err_o", sb_if.err_o, 0);
        check("err reset busy_o", sb_if.busy_o, 0);
        check("err reset state", dut.state_q, IDLE);
        do_wb(11);
        tick(); idle(); #1;
        check("stale wb flagged", sb_if.err_o, 1);

        // Reset in the middle of a drain abandons the fence
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0; idle(); issue(0, 0, 2'b00, 12, 1'b1);
        tick(); idle(); sb_if.fence_req_i = 1'b1;
        tick(); idle(); #1;
        check("middrain stalled", sb_if.stall_o, 1);
        rst = 1'b1;
        tick(); rst = 1'b0; idle(); #1;
        check("middrain reset stall", sb_if.stall_o, 0);
        check("middrain reset done", sb_if.fence_done_o, 0);
        tick(); idle(); #1;
        check("middrain no late done", sb_if.fence_done_o, 0);

        // Randomized traffic on a small register window to provoke hazards
        for (int c = 0; c < 4000; c++) begin
            tick(); idle();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) < 60) begin
                issue($urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 99) < 35) begin
                pend_list.delete();
                foreach (m_pend[i]) if (m_pend[i]) pend_list.push_back(i);
                if ((pend_list.size() == 0) || ($urandom_range(0, 9) == 0)) begin
                    do_wb($urandom_range(0, 15));
                end else begin
                    do_wb(pend_list[$urandom_range(0, pend_list.size() - 1)]);
                end
            end
            if ($urandom_range(0, 99) < 4) sb_if.fence_req_i = 1'b1;
        end

        tick(); idle(); rst = 1'b0;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
